// File: rtl/lookup_arb_pkg.sv
// ============================================================================
// Module      : lookup_arb_pkg
// Description : Shared types and key-layout constants for the lookup arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lookup_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LKP_DATA_W   = 243;
    localparam int IPV4_DST_LSB = 32;
    localparam int IPV4_DST_MSB = 63;

    function automatic logic [31:0] key_ipv4_dst(input logic [LKP_DATA_W-1:0] key);
        return key[IPV4_DST_MSB:IPV4_DST_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/lookup_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first set request after last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NPORT = 4
) (
    input  logic [NPORT-1:0] req,
    input  logic [3:0]       last,
    output logic             valid,
    output logic [3:0]       idx
);

    int w_dist;
    int w_best;

    // Distance of port i from the pointer, in search order; smallest wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_best = NPORT;
        w_dist = 0;
        for (int i = 0; i < NPORT; i++) begin
            w_dist = (((i - int'(last) - 1) % NPORT) + NPORT) % NPORT;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                valid  = 1'b1;
                idx    = 4'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lookup_arbiter.sv
// ============================================================================
// Module      : lookup_arbiter
// Description : Round-robin sharing of one lookupflow engine among NPORT ports.
//               Optional WAIT timeout enabled by LOOKUP_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lookup_arbiter
    import lookup_arb_pkg::*;
#(
    parameter int NPORT   = 4,
    parameter int DATA_W  = LKP_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [NPORT-1:0]        port_req,
    input  logic [NPORT*DATA_W-1:0] port_data,
    output logic [NPORT-1:0]        port_ack,
    output logic [NPORT-1:0]        port_err,
    output logic [3:0]              port_fwd_port,
    output logic                    of_lookup_req,
    output logic [DATA_W-1:0]       of_lookup_data,
    input  logic                    of_lookup_ack,
    input  logic                    of_lookup_err,
    input  logic [3:0]              of_lookup_fwd_port,
    output logic                    busy,
    output logic [3:0]              grant_id
);

    localparam logic [NPORT-1:0] c_onehot0  = NPORT'(1);
    localparam logic [3:0]       c_last_rst = 4'(NPORT - 1);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_last, w_last_nxt;
    logic [3:0]          r_grant, w_grant_nxt;
    logic                r_req, w_req_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [NPORT-1:0]    r_ack, w_ack_nxt;
    logic [NPORT-1:0]    r_err, w_err_nxt;
    logic [3:0]          r_fwd, w_fwd_nxt;
    logic                r_busy, w_busy_nxt;
    logic                w_pick_valid;
    logic [3:0]          w_pick_idx;
    logic                w_resp;
    logic                w_expire;
    logic [DATA_W-1:0]   w_key [16];

    // Keys unpacked into a 16-entry table so the 4-bit winner index selects directly.
    generate
        for (genvar i = 0; i < 16; i++) begin : g_key
            if (i < NPORT) begin : g_used
                assign w_key[i] = port_data[i*DATA_W +: DATA_W];
            end else begin : g_pad
                assign w_key[i] = '0;
            end
        end
    endgenerate

    rr_pick #(
        .NPORT (NPORT)
    ) u_rr_pick (
        .req   (port_req),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_resp = of_lookup_ack | of_lookup_err;

`ifdef LOOKUP_ARB_TIMEOUT_EN
    localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);
    logic [7:0] r_cnt, w_cnt_nxt;
    assign w_expire = (r_cnt == c_to_last);
`else
    localparam int c_unused_timeout = TIMEOUT;
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_req_nxt   = 1'b0;
        w_data_nxt  = r_data;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_fwd_nxt   = '0;
`ifdef LOOKUP_ARB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_WAIT;
                    w_last_nxt  = w_pick_idx;
                    w_grant_nxt = w_pick_idx;
                    w_req_nxt   = 1'b1;
                    w_data_nxt  = w_key[w_pick_idx];
`ifdef LOOKUP_ARB_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_WAIT: begin
                // A real response beats a same-cycle timeout; err beats ack.
                if (w_resp) begin
                    w_state_nxt = ST_DONE;
                    w_fwd_nxt   = of_lookup_fwd_port;
                    if (of_lookup_err) begin
                        w_err_nxt = c_onehot0 << r_grant;
                    end else begin
                        w_ack_nxt = c_onehot0 << r_grant;
                    end
                end else if (w_expire) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = c_onehot0 << r_grant;
                end else begin
`ifdef LOOKUP_ARB_TIMEOUT_EN
                    w_cnt_nxt = r_cnt + 8'd1;
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_last  <= c_last_rst;
            r_grant <= '0;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_fwd   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_req   <= w_req_nxt;
            r_data  <= w_data_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_fwd   <= w_fwd_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef LOOKUP_ARB_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`endif

    assign port_ack       = r_ack;
    assign port_err       = r_err;
    assign port_fwd_port  = r_fwd;
    assign of_lookup_req  = r_req;
    assign of_lookup_data = r_data;
    assign busy           = r_busy;
    assign grant_id       = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_lookup_arbiter.sv
// ============================================================================
// Module      : tb_lookup_arbiter
// Description : Directed scoreboard bench for lookup_arbiter with a stub engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lookup_arbiter;
    import lookup_arb_pkg::*;

    localparam int NP = 4;
    localparam int DW = LKP_DATA_W;
`ifdef LOOKUP_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    typedef struct packed {
        logic [NP-1:0] ack;
        logic [NP-1:0] err;
        logic [3:0]    fwd;
    } exp_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [NP-1:0]     port_req;
    logic [NP*DW-1:0]  port_data;
    logic [NP-1:0]     port_ack;
    logic [NP-1:0]     port_err;
    logic [3:0]        port_fwd_port;
    logic              of_lookup_req;
    logic [DW-1:0]     of_lookup_data;
    logic              of_lookup_ack;
    logic              of_lookup_err;
    logic [3:0]        of_lookup_fwd_port;
    logic              busy;
    logic [3:0]        grant_id;

    exp_t              sb[$];
    exp_t              mon_e;
    int                tests = 0;
    int                fails = 0;
    bit                mon_en = 1'b0;
    logic [DW-1:0]     keys [NP];
    logic [31:0]       dsts [NP];

    lookup_arbiter #(
        .NPORT   (NP),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .port_req           (port_req),
        .port_data          (port_data),
        .port_ack           (port_ack),
        .port_err           (port_err),
        .port_fwd_port      (port_fwd_port),
        .of_lookup_req      (of_lookup_req),
        .of_lookup_data     (of_lookup_data),
        .of_lookup_ack      (of_lookup_ack),
        .of_lookup_err      (of_lookup_err),
        .of_lookup_fwd_port (of_lookup_fwd_port),
        .busy               (busy),
        .grant_id           (grant_id)
    );

    always #4 sys_clk = ~sys_clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_exp(input logic [NP-1:0] a, input logic [NP-1:0] e, input logic [3:0] f);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.fwd = f;
        sb.push_back(x);
    endtask

    task automatic make_key(input int p, input logic [31:0] dst);
        logic [255:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        keys[p] = t[DW-1:0];
        keys[p][63:32] = dst;
        dsts[p] = dst;
        port_data[p*DW +: DW] = keys[p];
    endtask

    // Pulses from the arbiter are popped against the scoreboard.
    always @(negedge sys_clk) begin
        if (mon_en && (port_ack !== '0 || port_err !== '0)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {port_ack, port_err}, '0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_ack", port_ack, mon_e.ack);
                check("sb_err", port_err, mon_e.err);
                check("sb_fwd", port_fwd_port, mon_e.fwd);
            end
        end
    end

    // Stub engine + requester for one lookup of port p.
    task automatic serve(input logic [3:0] p, input logic [3:0] fwd, input logic a,
                         input logic e, input int dly, input bit scramble);
        int n;
        logic [NP-1:0] oh;
        oh = NP'(1) << p;
        n = 0;
        while (of_lookup_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", of_lookup_req, 1'b1);
        check("grant_id", grant_id, p);
        check("key", of_lookup_data, keys[p]);
        check("ipv4_dst", key_ipv4_dst(of_lookup_data), dsts[p]);
        check("busy_wait", busy, 1'b1);
        if (scramble) port_data[p*DW +: DW] = ~keys[p];
        for (int k = 0; k < dly; k++) begin
            tick();
            if (k == 0) check("req_one_cycle", of_lookup_req, 1'b0);
        end
        of_lookup_ack      = a;
        of_lookup_err      = e;
        of_lookup_fwd_port = fwd;
        tick();
        of_lookup_ack      = 1'b0;
        of_lookup_err      = 1'b0;
        of_lookup_fwd_port = '0;
        check("pulse_time", {port_ack, port_err}, e ? {4'b0000, oh} : {oh, 4'b0000});
        check("key_held", of_lookup_data, keys[p]);
        check("busy_done", busy, 1'b1);
        tick();
        port_req[p] = 1'b0;
        check("busy_idle", busy, 1'b0);
    endtask

    initial begin
        int n;
        sys_rst            = 1'b1;
        port_req           = '0;
        port_data          = '0;
        of_lookup_ack      = 1'b0;
        of_lookup_err      = 1'b0;
        of_lookup_fwd_port = '0;
        repeat (3) tick();
        check("rst_ack", port_ack, '0);
        check("rst_err", port_err, '0);
        check("rst_fwd", port_fwd_port, '0);
        check("rst_req", of_lookup_req, 1'b0);
        check("rst_data", of_lookup_data, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, '0);
        mon_en  = 1'b1;
        sys_rst = 1'b0;

        // Single port 0 lookup, ack two cycles after request.
        make_key(0, 32'h0A000001);
        port_req = 4'b0001;
        push_exp(4'b0001, 4'b0000, 4'd2);
        serve(4'd0, 4'd2, 1'b1, 1'b0, 2, 1'b0);
        tick();
        check("t1_fwd_clear", port_fwd_port, '0);
        check("t1_busy", busy, 1'b0);

        // Fresh pointer, all ports request: rotation 0,1,2,3.
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        for (int p = 0; p < NP; p++) make_key(p, 32'h0A000001 + 32'(p));
        port_req = 4'b1111;
        for (int p = 0; p < NP; p++) begin
            push_exp(NP'(1) << p, 4'b0000, 4'(p + 4));
            serve(4'(p), 4'(p + 4), 1'b1, 1'b0, 1 + p, 1'b0);
        end

        // Port 2 alone (key changed mid-WAIT), then ports 1 and 2 -> 1 first.
        make_key(2, 32'hC0A80002);
        port_req = 4'b0100;
        push_exp(4'b0100, 4'b0000, 4'd7);
        serve(4'd2, 4'd7, 1'b1, 1'b0, 1, 1'b1);
        make_key(1, 32'hC0A80101);
        make_key(2, 32'hC0A80102);
        port_req = 4'b0110;
        push_exp(4'b0010, 4'b0000, 4'd9);
        serve(4'd1, 4'd9, 1'b1, 1'b0, 1, 1'b0);
        push_exp(4'b0100, 4'b0000, 4'd11);
        serve(4'd2, 4'd11, 1'b1, 1'b0, 2, 1'b0);

        // ack and err together: err only.
        make_key(3, 32'h08080808);
        port_req = 4'b1000;
        push_exp(4'b0000, 4'b1000, 4'd5);
        serve(4'd3, 4'd5, 1'b1, 1'b1, 3, 1'b0);

        // Stale ack in IDLE.
        of_lookup_ack      = 1'b1;
        of_lookup_fwd_port = 4'd9;
        tick();
        of_lookup_ack      = 1'b0;
        of_lookup_fwd_port = '0;
        tick();
        check("stale_busy", busy, 1'b0);
        check("stale_req", of_lookup_req, 1'b0);
        check("stale_grant", grant_id, 4'd3);

`ifdef LOOKUP_ARB_TIMEOUT_EN
        // Silent engine: timeout error after TO WAIT cycles.
        make_key(1, 32'h0A0000FF);
        port_req = 4'b0010;
        n = 0;
        while (of_lookup_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("to_req", of_lookup_req, 1'b1);
        push_exp(4'b0000, 4'b0010, 4'd0);
        repeat (TO - 1) tick();
        check("to_not_yet", port_err, 4'b0000);
        tick();
        check("to_err", port_err, 4'b0010);
        check("to_fwd", port_fwd_port, 4'd0);
        tick();
        port_req = 4'b0000;
        of_lookup_ack = 1'b1;
        tick();
        of_lookup_ack = 1'b0;
        tick();
        check("to_stray_busy", busy, 1'b0);
`endif

        // Reset in WAIT, late engine ack ignored, port 0 first again.
        make_key(2, 32'h0A000002);
        port_req = 4'b0100;
        n = 0;
        while (of_lookup_req !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rw_req", of_lookup_req, 1'b1);
        tick();
        sys_rst  = 1'b1;
        port_req = 4'b0000;
        tick();
        check("rw_ack", port_ack, '0);
        check("rw_err", port_err, '0);
        check("rw_req0", of_lookup_req, 1'b0);
        check("rw_data", of_lookup_data, '0);
        check("rw_busy", busy, 1'b0);
        check("rw_grant", grant_id, '0);
        sys_rst            = 1'b0;
        of_lookup_ack      = 1'b1;
        of_lookup_fwd_port = 4'd3;
        tick();
        of_lookup_ack      = 1'b0;
        of_lookup_fwd_port = '0;
        tick();
        check("rw_late_busy", busy, 1'b0);
        for (int p = 0; p < NP; p++) make_key(p, 32'h0A0001_00 + 32'(p));
        port_req = 4'b1111;
        push_exp(4'b0001, 4'b0000, 4'd1);
        serve(4'd0, 4'd1, 1'b1, 1'b0, 1, 1'b0);
        port_req = 4'b0000;

        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
